llc_pending_tracker: RTL

//   Parametrised successor to the LLC's single-entry control-register bank.
//   - Generic set/clear flag bank (NUM_FLAGS bits), replacing per-flag hand-coded registers.
//   - DEPTH-entry FIFO of stalled requests (set, tag) with a set-conflict lookup.
//   - Reset/flush set walker with a done pulse.

---
 rtl/llc_pending_pkg.sv | 29 ++
 rtl/llc_flag_bank.sv | 31 +++
 rtl/llc_pending_tracker.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/llc_pending_pkg.sv
// Shared types and flag indices for the LLC pending-request tracker.
// Set/tag geometry defaults apply only when cache_types.svh has not already defined it.
`ifndef LLC_SET_BITS
`define LLC_SET_BITS 10
`endif
`ifndef LLC_TAG_BITS
`define LLC_TAG_BITS 18
`endif
`ifndef LLC_SETS
`define LLC_SETS 1024
`endif

package llc_pending_pkg;

    typedef logic [`LLC_SET_BITS-1:0] llc_set_t;
    typedef logic [`LLC_TAG_BITS-1:0] llc_tag_t;

    localparam int FLG_RST_STALL   = 0;
    localparam int FLG_FLUSH_STALL = 1;
    localparam int FLG_REQ_STALL   = 2;
    localparam int FLG_EVICT_STALL = 3;
    localparam int FLG_DMA_STALL   = 4;

    typedef struct packed {
        llc_set_t set;
        llc_tag_t tag;
    } llc_stall_entry_t;

endpackage

// File: rtl/llc_flag_bank.sv
// Generic per-bit set/clear flag register bank; clear dominates set on the same bit.
module llc_flag_bank
    import llc_pending_pkg::*;
#(
    parameter int                   NUM_FLAGS    = 16,
    parameter logic [NUM_FLAGS-1:0] FLAG_RST_VAL = {{(NUM_FLAGS-1){1'b0}}, 1'b1}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rst_state,
    input  logic [NUM_FLAGS-1:0] flag_set,
    input  logic [NUM_FLAGS-1:0] flag_clr,
    output logic [NUM_FLAGS-1:0] flags
);

    logic [NUM_FLAGS-1:0] flags_r;

    // Flag register: soft reset overrides strobes, clear beats set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_r <= FLAG_RST_VAL;
        end else if (rst_state) begin
            flags_r <= FLAG_RST_VAL;
        end else begin
            flags_r <= (flags_r | flag_set) & ~flag_clr;
        end
    end

    assign flags = flags_r;

endmodule

// File: rtl/llc_pending_tracker.sv
// LLC pending tracker: flag bank, stalled-request FIFO with set lookup, and set walker.
// Optional statistics (hwm, overflow_err) are built only with LLC_PENDING_STATS_EN defined.
module llc_pending_tracker
    import llc_pending_pkg::*;
#(
    parameter int                   NUM_FLAGS    = 16,
    parameter logic [NUM_FLAGS-1:0] FLAG_RST_VAL = 16'h0001,
    parameter int                   DEPTH        = 4,
    parameter int                   SET_BITS     = `LLC_SET_BITS,
    parameter int                   TAG_BITS     = `LLC_TAG_BITS,
    parameter int                   NUM_SETS     = `LLC_SETS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rst_state,
    input  logic [NUM_FLAGS-1:0]       flag_set,
    input  logic [NUM_FLAGS-1:0]       flag_clr,
    output logic [NUM_FLAGS-1:0]       flags,
    input  logic                       push_valid,
    input  logic [SET_BITS-1:0]        push_set,
    input  logic [TAG_BITS-1:0]        push_tag,
    output logic                       push_ready,
    output logic                       pop_valid,
    output logic [SET_BITS-1:0]        pop_set,
    output logic [TAG_BITS-1:0]        pop_tag,
    input  logic                       pop_ready,
    input  logic [SET_BITS-1:0]        lookup_set,
    output logic                       lookup_hit,
    output logic [$clog2(DEPTH+1)-1:0] count,
    input  logic                       walk_start,
    input  logic                       walk_incr,
    output logic [SET_BITS-1:0]        walk_set,
    output logic                       walk_busy,
    output logic                       walk_done,
    output logic [$clog2(DEPTH+1)-1:0] hwm,
    output logic                       overflow_err
);

    localparam int                  CW       = $clog2(DEPTH+1);
    localparam int                  PW       = $clog2(DEPTH);
    localparam logic [CW-1:0]       FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0]       LAST_PTR = PW'(DEPTH-1);
    localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(NUM_SETS-1);

    logic [SET_BITS-1:0] set_mem_r [DEPTH];
    logic [TAG_BITS-1:0] tag_mem_r [DEPTH];
    logic [DEPTH-1:0]    valid_r;
    logic [DEPTH-1:0]    valid_nxt_s;
    logic [DEPTH-1:0]    match_s;
    logic [PW-1:0]       wr_ptr_r;
    logic [PW-1:0]       rd_ptr_r;
    logic [CW-1:0]       count_r;
    logic [CW-1:0]       count_nxt_s;
    logic                not_empty_s;
    logic                push_fire_s;
    logic                pop_fire_s;
    logic [SET_BITS-1:0] walk_set_r;
    logic                walk_busy_r;
    logic                walk_done_r;

    llc_flag_bank #(
        .NUM_FLAGS    (NUM_FLAGS),
        .FLAG_RST_VAL (FLAG_RST_VAL)
    ) u_flag_bank (
        .clk       (clk),
        .rst       (rst),
        .rst_state (rst_state),
        .flag_set  (flag_set),
        .flag_clr  (flag_clr),
        .flags     (flags)
    );

    // Handshake qualification, next occupancy and next valid map
    always_comb begin
        not_empty_s = (count_r != {CW{1'b0}});
        push_fire_s = push_valid && (count_r != FULL_CNT);
        pop_fire_s  = pop_ready && not_empty_s;
        valid_nxt_s = valid_r;
        if (pop_fire_s) begin
            valid_nxt_s[rd_ptr_r] = 1'b0;
        end else begin
            valid_nxt_s[rd_ptr_r] = valid_r[rd_ptr_r];
        end
        if (push_fire_s) begin
            valid_nxt_s[wr_ptr_r] = 1'b1;
        end else begin
            valid_nxt_s[wr_ptr_r] = valid_nxt_s[wr_ptr_r];
        end
        if (push_fire_s && !pop_fire_s) begin
            count_nxt_s = count_r + CW'(1'b1);
        end else if (pop_fire_s && !push_fire_s) begin
            count_nxt_s = count_r - CW'(1'b1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Conflict lookup sees only committed entries, never this cycle's push
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match_s[i] = valid_r[i] && (set_mem_r[i] == lookup_set);
        end
    end

    // FIFO payload storage; contents are qualified by valid_r so no reset is needed
    always_ff @(posedge clk) begin
        if (push_fire_s && !rst_state) begin
            set_mem_r[wr_ptr_r] <= push_set;
            tag_mem_r[wr_ptr_r] <= push_tag;
        end
    end

    // FIFO control: pointers wrap explicitly so DEPTH need not be a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            valid_r  <= {DEPTH{1'b0}};
        end else if (rst_state) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            valid_r  <= {DEPTH{1'b0}};
        end else begin
            if (push_fire_s) begin
                wr_ptr_r <= (wr_ptr_r == LAST_PTR) ? {PW{1'b0}} : wr_ptr_r + PW'(1'b1);
            end
            if (pop_fire_s) begin
                rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? {PW{1'b0}} : rd_ptr_r + PW'(1'b1);
            end
            count_r <= count_nxt_s;
            valid_r <= valid_nxt_s;
        end
    end

    // Set walker: start restarts at 0 and beats incr; incr while idle is dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            walk_set_r  <= {SET_BITS{1'b0}};
            walk_busy_r <= 1'b0;
            walk_done_r <= 1'b0;
        end else if (rst_state) begin
            walk_set_r  <= {SET_BITS{1'b0}};
            walk_busy_r <= 1'b0;
            walk_done_r <= 1'b0;
        end else begin
            walk_done_r <= 1'b0;
            if (walk_start) begin
                walk_set_r  <= {SET_BITS{1'b0}};
                walk_busy_r <= 1'b1;
            end else if (walk_incr && walk_busy_r) begin
                if (walk_set_r == LAST_SET) begin
                    walk_set_r  <= {SET_BITS{1'b0}};
                    walk_busy_r <= 1'b0;
                    walk_done_r <= 1'b1;
                end else begin
                    walk_set_r <= walk_set_r + SET_BITS'(1'b1);
                end
            end
        end
    end

`ifdef LLC_PENDING_STATS_EN
    logic [CW-1:0] hwm_r;
    logic          overflow_err_r;

    // Statistics follow post-edge occupancy so hwm never lags count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hwm_r          <= {CW{1'b0}};
            overflow_err_r <= 1'b0;
        end else if (rst_state) begin
            hwm_r          <= {CW{1'b0}};
            overflow_err_r <= 1'b0;
        end else begin
            if (count_nxt_s > hwm_r) begin
                hwm_r <= count_nxt_s;
            end
            if (push_valid && !push_ready) begin
                overflow_err_r <= 1'b1;
            end
        end
    end

    assign hwm          = hwm_r;
    assign overflow_err = overflow_err_r;
`else
    assign hwm          = {CW{1'b0}};
    assign overflow_err = 1'b0;
`endif

    assign push_ready = (count_r != FULL_CNT);
    assign pop_valid  = not_empty_s;
    assign pop_set    = not_empty_s ? set_mem_r[rd_ptr_r] : {SET_BITS{1'b0}};
    assign pop_tag    = not_empty_s ? tag_mem_r[rd_ptr_r] : {TAG_BITS{1'b0}};
    assign lookup_hit = |match_s;
    assign count      = count_r;
    assign walk_set   = walk_set_r;
    assign walk_busy  = walk_busy_r;
    assign walk_done  = walk_done_r;

endmodule
